// File: rtl/uart_out_responder_pkg.sv
// Shared constants and types for the core output-request UART responder.
// Also holds the register width and UART framing constants used across the core.
package uart_out_responder_pkg;

   localparam int REG_W            = 32;
   localparam int UART_DATA_W      = 8;
   localparam int UART_FRAME_BITS  = 10;
   localparam int UART_DEFAULT_CPB = 868;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_e;

endpackage

// File: rtl/uart_out_responder_tx_serializer.sv
// 8N1 UART transmitter: frames one byte per start pulse, LSB first.
// txd comes straight from a flop loaded with the value for the next state.
module uart_tx_serializer
   import uart_out_responder_pkg::*;
#(
   parameter int CLK_PER_BIT = UART_DEFAULT_CPB
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic [UART_DATA_W-1:0] byte_in,
   input  logic                   start,
   output logic                   ready,
   output logic                   txd
);

   localparam int CNT_W = $clog2(CLK_PER_BIT);
   localparam int IDX_W = $clog2(UART_DATA_W);

   tx_state_e              state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [UART_DATA_W-1:0] shift_q, shift_d;
   logic                   txd_q, txd_d;
   logic                   last_tick;

   assign last_tick = (cnt_q == CNT_W'(CLK_PER_BIT - 1));

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= TX_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         txd_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         txd_q   <= txd_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      case (state_q)
         TX_IDLE: begin
            if (start) begin
               state_d = TX_START;
               cnt_d   = '0;
               shift_d = byte_in;
            end
         end
         TX_START: begin
            if (last_tick) begin
               state_d = TX_DATA;
               cnt_d   = '0;
               idx_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         TX_DATA: begin
            if (last_tick) begin
               cnt_d   = '0;
               shift_d = shift_q >> 1;
               if (idx_q == IDX_W'(UART_DATA_W - 1)) begin
                  state_d = TX_STOP;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         TX_STOP: begin
            if (last_tick) begin
               state_d = TX_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = TX_IDLE;
      endcase
   end

   // Line level is decided from the next state so txd changes on the same edge as the FSM.
   always_comb begin
      ready = (state_q == TX_IDLE);
      case (state_d)
         TX_START: txd_d = 1'b0;
         TX_DATA:  txd_d = shift_d[0];
         default:  txd_d = 1'b1;
      endcase
   end

   assign txd = txd_q;

endmodule

// File: rtl/uart_out_responder.sv
// Responder for the core's out_req/out_data/out_busy port: byte FIFO feeding a UART
// transmitter, with early busy back-pressure and a sticky overflow flag.
module uart_out_responder
   import uart_out_responder_pkg::*;
#(
   parameter int CLK_PER_BIT = UART_DEFAULT_CPB,
   parameter int FIFO_DEPTH  = 16,
   parameter int BUSY_MARGIN = 2
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             out_req,
   input  logic [REG_W-1:0] out_data,
   output logic             out_busy,
   output logic             txd,
   output logic             tx_active,
   output logic             overflow
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] BUSY_LVL = CNT_W'(FIFO_DEPTH - BUSY_MARGIN);

   logic [UART_DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic                   busy_q, busy_d;
   logic                   ovf_q, ovf_d;
   logic                   ser_ready;
   logic                   pop;
   logic                   push_ok;
   logic                   unused_data;

   assign unused_data = ^out_data[REG_W-1:UART_DATA_W];

   // A push at full is still accepted when the serializer frees a slot in the same cycle.
   assign pop     = ser_ready && (count_q != '0);
   assign push_ok = out_req && ((count_q != FULL_LVL) || pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop);
      busy_d   = (count_d >= BUSY_LVL);
      ovf_d    = ovf_q | (out_req & ~push_ok);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         busy_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         busy_q   <= busy_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= out_data[UART_DATA_W-1:0];
      end
   end

   uart_tx_serializer #(
      .CLK_PER_BIT(CLK_PER_BIT)
   ) u_serializer (
      .clk    (clk),
      .rstn   (rstn),
      .byte_in(mem_q[rd_ptr_q]),
      .start  (pop),
      .ready  (ser_ready),
      .txd    (txd)
   );

   assign out_busy  = busy_q;
   assign overflow  = ovf_q;
   assign tx_active = ~ser_ready | (count_q != '0);

endmodule

// File: tb/tb_uart_out_responder.sv
// Randomized bench for uart_out_responder: a frame-position reference model predicts
// txd, out_busy, tx_active and overflow every cycle.
module tb_uart_out_responder;
   import uart_out_responder_pkg::*;

   localparam int CPB    = 4;
   localparam int DEPTH  = 4;
   localparam int MARGIN = 1;
   localparam int FRAME  = UART_FRAME_BITS * CPB;

   logic             clk = 1'b0;
   logic             rstn = 1'b0;
   logic             out_req = 1'b0;
   logic [REG_W-1:0] out_data = '0;
   logic             out_busy, txd, tx_active, overflow;

   uart_out_responder #(
      .CLK_PER_BIT(CPB),
      .FIFO_DEPTH (DEPTH),
      .BUSY_MARGIN(MARGIN)
   ) dut (
      .clk      (clk),
      .rstn     (rstn),
      .out_req  (out_req),
      .out_data (out_data),
      .out_busy (out_busy),
      .txd      (txd),
      .tx_active(tx_active),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: queued bytes, byte on the line and cycles left in its frame.
   logic [7:0] mq[$];
   logic [7:0] cur_byte = '0;
   int         frame_left = 0;
   logic       m_ovf = 1'b0;
   logic       exp_txd = 1'b1, exp_busy = 1'b0, exp_active = 1'b0;

   task automatic cycle(input logic req, input logic [REG_W-1:0] data, input logic rn);
      int p, b;
      logic pop;
      out_req  = req;
      out_data = data;
      rstn     = rn;
      @(posedge clk);
      if (!rn) begin
         mq.delete();
         frame_left = 0;
         m_ovf      = 1'b0;
      end else begin
         pop = (frame_left == 0) && (mq.size() > 0);
         if (pop) begin
            cur_byte   = mq.pop_front();
            frame_left = FRAME;
         end else if (frame_left > 0) begin
            frame_left--;
         end
         if (req) begin
            if (mq.size() < DEPTH) begin
               mq.push_back(data[7:0]);
               $display("[%0t] push %02h accepted, queued=%0d", $time, data[7:0], mq.size());
            end else begin
               m_ovf = 1'b1;
               $display("[%0t] push %02h dropped (queue full)", $time, data[7:0]);
            end
         end
      end
      if (frame_left > 0) begin
         p = FRAME - frame_left;
         b = p / CPB;
         exp_txd = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : cur_byte[b-1];
      end else begin
         exp_txd = 1'b1;
      end
      exp_busy   = (mq.size() >= DEPTH - MARGIN);
      exp_active = (frame_left > 0) || (mq.size() > 0);
      #1;
      out_req = 1'b0;
   endtask

   task automatic test_reset();
      cycle(1'b0, '0, 1'b0);
      cycle(1'b0, '0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, '0, 1'b1);
         checks += 4;
         if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd cyc%0d got %b want 1", i, txd); end
         if (out_busy !== 1'b0) begin errors++; $display("FAIL reset_busy cyc%0d got %b want 0", i, out_busy); end
         if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf cyc%0d got %b want 0", i, overflow); end
         if (tx_active !== 1'b0) begin errors++; $display("FAIL reset_active cyc%0d got %b want 0", i, tx_active); end
      end
   endtask

   task automatic test_single_push();
      logic [9:0] frame_bits;
      frame_bits = {1'b1, 8'h55, 1'b0};
      cycle(1'b1, 32'hDEADBE55, 1'b1);
      checks++;
      if (txd !== 1'b1) begin errors++; $display("FAIL single_t+1 txd got %b want 1", txd); end
      for (int k = 1; k <= 41; k++) begin
         cycle(1'b0, '0, 1'b1);
         checks++;
         if (k <= 40) begin
            if (txd !== frame_bits[(k-1)/CPB]) begin
               errors++; $display("FAIL single_bit t+%0d txd got %b want %b", k+1, txd, frame_bits[(k-1)/CPB]);
            end
         end else if (tx_active !== 1'b0 || txd !== 1'b1) begin
            errors++; $display("FAIL single_end active got %b want 0, txd got %b want 1", tx_active, txd);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [REG_W-1:0] d;
      for (int i = 0; i < 4; i++) begin
         d = $urandom();
         d[7:0] = 8'(i + 1);
         cycle(1'b1, d, 1'b1);
         checks++;
         if (out_busy !== exp_busy) begin errors++; $display("FAIL b2b_busy push%0d got %b want %b", i, out_busy, exp_busy); end
      end
      checks++;
      if (out_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_final got %b want 1", out_busy); end
      for (int n = 0; n < 300 && exp_active; n++) begin
         cycle(1'b0, '0, 1'b1);
         checks += 3;
         if (txd !== exp_txd) begin errors++; $display("FAIL b2b_txd n=%0d got %b want %b", n, txd, exp_txd); end
         if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_ovf n=%0d got %b want 0", n, overflow); end
         if (out_busy !== exp_busy) begin errors++; $display("FAIL b2b_busy n=%0d got %b want %b", n, out_busy, exp_busy); end
      end
      checks++;
      if (tx_active !== 1'b0) begin errors++; $display("FAIL b2b_drain active got %b want 0", tx_active); end
   endtask

   task automatic test_push_at_pop();
      int n;
      cycle(1'b0, '0, 1'b0);
      for (int i = 0; i < 5; i++) cycle(1'b1, 32'(8'h10 + i), 1'b1);
      for (n = 0; n < 100 && !(frame_left == 0 && mq.size() == DEPTH); n++) begin
         cycle(1'b0, '0, 1'b1);
         checks++;
         if (txd !== exp_txd) begin errors++; $display("FAIL pap_fill_txd n=%0d got %b want %b", n, txd, exp_txd); end
      end
      checks++;
      if (n >= 100) begin errors++; $display("FAIL pap_setup full-idle not reached got %0d cycles want <100", n); end
      cycle(1'b1, 32'hABCD0066, 1'b1);
      checks += 3;
      if (overflow !== 1'b0) begin errors++; $display("FAIL pap_ovf got %b want 0", overflow); end
      if (out_busy !== 1'b1) begin errors++; $display("FAIL pap_busy got %b want 1", out_busy); end
      if (txd !== 1'b0) begin errors++; $display("FAIL pap_start txd got %b want 0", txd); end
      for (int k = 0; k < 300 && exp_active; k++) begin
         cycle(1'b0, '0, 1'b1);
         checks += 2;
         if (txd !== exp_txd) begin errors++; $display("FAIL pap_txd k=%0d got %b want %b", k, txd, exp_txd); end
         if (overflow !== 1'b0) begin errors++; $display("FAIL pap_ovf k=%0d got %b want 0", k, overflow); end
      end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 5; i++) cycle(1'b1, 32'(8'h20 + i), 1'b1);
      cycle(1'b1, 32'h123456FF, 1'b1);
      checks++;
      if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow); end
      for (int k = 0; k < 300 && exp_active; k++) begin
         cycle(1'b0, '0, 1'b1);
         checks += 2;
         if (txd !== exp_txd) begin errors++; $display("FAIL ovf_txd k=%0d got %b want %b", k, txd, exp_txd); end
         if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky k=%0d got %b want 1", k, overflow); end
      end
   endtask

   task automatic test_reset_mid_frame();
      int n;
      cycle(1'b1, 32'h000000A5, 1'b1);
      for (n = 0; n < 50 && !(frame_left > 0 && FRAME - frame_left == 3 * CPB); n++) cycle(1'b0, '0, 1'b1);
      checks++;
      if (txd !== exp_txd) begin errors++; $display("FAIL rmf_pre txd got %b want %b", txd, exp_txd); end
      cycle(1'b0, '0, 1'b0);
      checks += 4;
      if (txd !== 1'b1) begin errors++; $display("FAIL rmf_txd got %b want 1", txd); end
      if (tx_active !== 1'b0) begin errors++; $display("FAIL rmf_active got %b want 0", tx_active); end
      if (out_busy !== 1'b0) begin errors++; $display("FAIL rmf_busy got %b want 0", out_busy); end
      if (overflow !== 1'b0) begin errors++; $display("FAIL rmf_ovf got %b want 0", overflow); end
      for (int k = 0; k < FRAME; k++) begin
         cycle(1'b0, '0, 1'b1);
         checks++;
         if (txd !== 1'b1) begin errors++; $display("FAIL rmf_quiet k=%0d txd got %b want 1", k, txd); end
      end
      cycle(1'b1, 32'h0000003C, 1'b1);
      for (int k = 0; k < 300 && exp_active; k++) begin
         cycle(1'b0, '0, 1'b1);
         checks++;
         if (txd !== exp_txd) begin errors++; $display("FAIL rmf_after k=%0d txd got %b want %b", k, txd, exp_txd); end
      end
   endtask

   task automatic test_random();
      int rates[3] = '{5, 12, 40};
      logic req, rn;
      for (int s = 0; s < 3; s++) begin
         for (int k = 0; k < 300; k++) begin
            req = ($urandom_range(0, 99) < rates[s]);
            rn  = ($urandom_range(0, 399) != 0);
            cycle(req, $urandom(), rn);
            checks += 4;
            if (txd !== exp_txd) begin errors++; $display("FAIL rnd_txd s%0d k%0d got %b want %b", s, k, txd, exp_txd); end
            if (out_busy !== exp_busy) begin errors++; $display("FAIL rnd_busy s%0d k%0d got %b want %b", s, k, out_busy, exp_busy); end
            if (tx_active !== exp_active) begin errors++; $display("FAIL rnd_active s%0d k%0d got %b want %b", s, k, tx_active, exp_active); end
            if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf s%0d k%0d got %b want %b", s, k, overflow, m_ovf); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_push();
      test_back_to_back();
      test_push_at_pop();
      test_overflow();
      test_reset_mid_frame();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
